push_pop_sequencer: RTL and testbench
=====================================

PUSH_POP_SEQUENCER -- requirements
Module: push_pop_sequencer

Interface
REQ-001 SHALL have parameter BP_SKIP_BIT, default 5, the mask bit that discards one pop slot without a bus cycle.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  clock enable; state advances only when ce=1.
REQ-005 SHALL have port start  input  1  begin sequence; sampled only in IDLE.
REQ-006 SHALL have port push_mask  input  16  registers to push, STACK_* bit encoding.
REQ-007 SHALL have port pop_mask  input  16  registers to pop, STACK_* bit encoding.
REQ-008 SHALL have port sp_in  input  16  starting SP value, sampled with start.
REQ-009 SHALL have port reg_sel  output  4  bit index of register currently serviced.
REQ-010 SHALL have port reg_rdata  input  16  combinational value of register reg_sel (push source).
REQ-011 SHALL have port reg_we / reg_wdata  output  1/16  pop result write strobe and data.
REQ-012 SHALL have port bus_req / bus_write / bus_addr / bus_wdata  output  1/1/16/16  stack-segment word access.
REQ-013 SHALL have port bus_ack / bus_rdata  input  1/16  access complete; rdata valid in ack cycle.
REQ-014 SHALL have port busy / done / sp_we / sp_out  output  1/1/1/16  status, 1-cycle completion pulse, final SP write.

Function
REQ-015 SHALL use states IDLE, SCAN, BUS, DONE.
REQ-016 IDLE: on start, latch push_mask, pop_mask, sp_in into working copies, go SCAN; busy=1 from next cycle until DONE exits.
REQ-017 SCAN: push phase while working push mask nonzero, selecting lowest set bit (ascending order 0..15).
REQ-018 SCAN: pop phase once push mask zero, selecting highest set pop bit (descending order 15..0).
REQ-019 Push slot: SP<=SP-2, bus_addr=SP-2, bus_write=1, bus_wdata=reg_rdata captured in SCAN, go BUS.
REQ-020 Pop slot: bus_addr=SP, bus_write=0, go BUS; on ack SP<=SP+2.
REQ-021 Pop bit BP_SKIP_BIT: no bus cycle, SP<=SP+2, clear bit, stay SCAN (one cycle).
REQ-022 BUS: bus_req=1 with addr/write/wdata stable until bus_ack; on ack clear serviced bit, return SCAN; unlimited wait states.
REQ-023 Pop ack: reg_we=1 for the ack cycle, reg_wdata=bus_rdata, reg_sel=serviced bit.
REQ-024 SCAN with both working masks zero: go DONE; DONE asserts done=1, sp_we=1, sp_out=final SP for one cycle, then IDLE.
REQ-025 start with both masks zero: DONE one cycle after start, no bus_req.
REQ-026 SP arithmetic modulo 2^16 (wrap 0x0000-2=0xFFFE, 0xFFFE+2=0x0000).
REQ-027 start while busy ignored; bus_ack while bus_req=0 ignored.
REQ-028 ce=0 freezes state and all outputs; pulses (done, sp_we, reg_we) are not repeated.
REQ-029 One bus access per set bit except BP_SKIP_BIT during pop; BP_SKIP_BIT in push mask treated as normal push.

Reset
REQ-030 reset SHALL force IDLE, clear working masks, and drive busy, done, bus_req, bus_write, reg_we, sp_we to 0 and bus_addr, bus_wdata, reg_sel, reg_wdata, sp_out to 0 next cycle.
REQ-031 reset mid-sequence SHALL abandon the sequence with no sp_we and no further reg_we; reset has priority over ce and start.

Verification
REQ-032 PUSH R: push_mask=0x01DF, sp_in=0x0100, ack immediate -> writes at 0x00FE,FC,FA,F8,F6,F4,F2,F0 with reg_sel 0,1,2,3,4,6,7,8; sp_out=0x00F0.
REQ-033 POP R: pop_mask=0x01EF, sp_in=0x00F0 -> reads at 0x00F0(8),F2(7),F4(6), skip F6, F8(3),FA(2),FC(1),FE(0); 7 reg_we; sp_out=0x0100.
REQ-034 Wrap: push_mask=0x4000, sp_in=0x0000 -> one write at 0xFFFE, sp_out=0xFFFE.
REQ-035 Empty: both masks 0 -> done and sp_we one cycle after start, sp_out=sp_in, bus_req never high.
REQ-036 Push+pop: push_mask=0x0001, pop_mask=0x0002, sp_in=0x0010, 3 wait states per ack -> write 0x000E (sel 0), then read 0x000E (sel 1), sp_out=0x0010; addr stable during waits.
REQ-037 Reset: assert reset while bus_req held waiting for ack -> next cycle bus_req=0, busy=0, no done/sp_we.

Source files
------------

// File: rtl/push_pop_sequencer.sv
// Multi-register push/pop sequencer: walks a push mask (ascending) then a pop mask
// (descending), issuing one stack-segment word access per selected register.
module push_pop_sequencer #(
  parameter int unsigned BP_SKIP_BIT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  output logic [3:0]  reg_sel,
  input  logic [15:0] reg_rdata,
  output logic        reg_we,
  output logic [15:0] reg_wdata,
  output logic        bus_req,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        done,
  output logic        sp_we,
  output logic [15:0] sp_out
);

  localparam logic [3:0] SKIP = 4'(BP_SKIP_BIT);

  typedef enum logic [1:0] {IDLE, SCAN, BUS, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] push_m, push_nx, pop_m, pop_nx, sp, sp_nx;
  logic [3:0]  cur, cur_nx, push_idx, pop_idx;
  logic        req_nx, wr_nx, busy_nx, done_nx, sp_we_nx;
  logic [15:0] addr_nx, wdata_nx, sp_out_nx;

  always_comb begin
    push_idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (push_m[i-1]) push_idx = 4'(i - 1);
    end
    pop_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pop_m[i]) pop_idx = 4'(i);
    end
  end

  // reg_sel is combinational in SCAN so the register file can present the push
  // operand in the same cycle it is captured into bus_wdata.
  always_comb begin
    reg_sel   = (state == SCAN) ? ((push_m != '0) ? push_idx : pop_idx) : cur;
    reg_we    = ce && !reset && (state == BUS) && !bus_write && bus_ack;
    reg_wdata = reg_we ? bus_rdata : '0;
  end

  always_comb begin
    state_nx  = state;
    push_nx   = push_m;
    pop_nx    = pop_m;
    sp_nx     = sp;
    cur_nx    = cur;
    req_nx    = bus_req;
    wr_nx     = bus_write;
    addr_nx   = bus_addr;
    wdata_nx  = bus_wdata;
    busy_nx   = busy;
    done_nx   = 1'b0;
    sp_we_nx  = 1'b0;
    sp_out_nx = sp_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          busy_nx = 1'b1;
          push_nx = push_mask;
          pop_nx  = pop_mask;
          sp_nx   = sp_in;
          if (push_mask == '0 && pop_mask == '0) begin
            state_nx  = DONE;
            done_nx   = 1'b1;
            sp_we_nx  = 1'b1;
            sp_out_nx = sp_in;
          end else begin
            state_nx = SCAN;
          end
        end
      end
      SCAN: begin
        if (push_m != '0) begin
          cur_nx   = push_idx;
          sp_nx    = sp - 16'd2;
          addr_nx  = sp - 16'd2;
          wr_nx    = 1'b1;
          wdata_nx = reg_rdata;
          req_nx   = 1'b1;
          state_nx = BUS;
        end else if (pop_m != '0) begin
          if (pop_idx == SKIP) begin
            pop_nx[pop_idx] = 1'b0;
            sp_nx           = sp + 16'd2;
          end else begin
            cur_nx   = pop_idx;
            addr_nx  = sp;
            wr_nx    = 1'b0;
            req_nx   = 1'b1;
            state_nx = BUS;
          end
        end else begin
          state_nx  = DONE;
          done_nx   = 1'b1;
          sp_we_nx  = 1'b1;
          sp_out_nx = sp;
        end
      end
      BUS: begin
        if (bus_ack) begin
          req_nx   = 1'b0;
          state_nx = SCAN;
          if (bus_write) begin
            push_nx[cur] = 1'b0;
          end else begin
            pop_nx[cur] = 1'b0;
            sp_nx       = sp + 16'd2;
          end
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      push_m    <= '0;
      pop_m     <= '0;
      sp        <= '0;
      cur       <= '0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sp_we     <= 1'b0;
      sp_out    <= '0;
    end else if (ce) begin
      state     <= state_nx;
      push_m    <= push_nx;
      pop_m     <= pop_nx;
      sp        <= sp_nx;
      cur       <= cur_nx;
      bus_req   <= req_nx;
      bus_write <= wr_nx;
      bus_addr  <= addr_nx;
      bus_wdata <= wdata_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      sp_we     <= sp_we_nx;
      sp_out    <= sp_out_nx;
    end
  end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Directed bench for push_pop_sequencer: bus responder with programmable wait
// states, register-file model, and transaction logs compared against hand tables.
module tb_push_pop_sequencer;

  logic        clk, reset, ce, start;
  logic [15:0] push_mask, pop_mask, sp_in;
  logic [3:0]  reg_sel;
  logic [15:0] reg_rdata, reg_wdata, bus_addr, bus_wdata, bus_rdata, sp_out;
  logic        reg_we, bus_req, bus_write, bus_ack, busy, done, sp_we;

  push_pop_sequencer #(.BP_SKIP_BIT(5)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .done(done), .sp_we(sp_we), .sp_out(sp_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int waits_cfg = 0;
  int wcnt = 0;

  logic [15:0] b_addr[$], b_data[$], r_data[$];
  logic        b_wr[$];
  logic [3:0]  b_sel[$], r_sel[$];
  int          done_cnt, spwe_cnt, done_cyc, start_cyc, req_cycles, unstable;
  logic [15:0] sp_final, last_addr;
  logic        req_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always_comb begin
    reg_rdata = 16'hC0D0 | {12'h000, reg_sel};
    bus_rdata = bus_addr ^ 16'h5A5A;
  end

  // Bus slave: acks after waits_cfg idle cycles of a held request.
  initial begin
    bus_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req && !bus_ack) begin
        if (wcnt >= waits_cfg) begin
          bus_ack = 1'b1;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        bus_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  initial begin
    req_prev = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (ce && bus_req && bus_ack) begin
        b_addr.push_back(bus_addr);
        b_wr.push_back(bus_write);
        b_data.push_back(bus_wdata);
        b_sel.push_back(reg_sel);
      end
      if (bus_req) begin
        req_cycles++;
        if (req_prev && bus_addr != last_addr) unstable++;
        last_addr = bus_addr;
      end
      req_prev = bus_req && !bus_ack;
      if (reg_we) begin
        r_sel.push_back(reg_sel);
        r_data.push_back(reg_wdata);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sp_we) begin
        spwe_cnt++;
        sp_final = sp_out;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    b_addr.delete(); b_wr.delete(); b_data.delete(); b_sel.delete();
    r_sel.delete(); r_data.delete();
    done_cnt = 0; spwe_cnt = 0; req_cycles = 0; unstable = 0;
  endtask

  task automatic launch(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp, input int waits);
    clear_logs();
    waits_cfg = waits;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    push_mask = pm; pop_mask = qm; sp_in = sp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_seq();
    for (int k = 0; k < 400; k++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("sp_we_pulses", spwe_cnt, 1);
  endtask

  task automatic check_bus(input int n, input logic wr, input logic [15:0] ea[8], input logic [3:0] es[8]);
    chk("bus_count", b_addr.size(), n);
    for (int i = 0; i < n && i < b_addr.size(); i++) begin
      chk("bus_addr", b_addr[i], ea[i]);
      chk("bus_write", b_wr[i], wr);
      chk("bus_sel", b_sel[i], es[i]);
      if (wr) chk("bus_wdata", b_data[i], 16'hC0D0 | {12'h000, es[i]});
    end
    chk("reg_we_count", r_sel.size(), wr ? 0 : n);
    if (!wr) begin
      for (int i = 0; i < n && i < r_sel.size(); i++) begin
        chk("reg_we_sel", r_sel[i], es[i]);
        chk("reg_wdata", r_data[i], ea[i] ^ 16'h5A5A);
      end
    end
  endtask

  logic [15:0] ea[8];
  logic [3:0]  es[8];

  initial begin
    reset = 1'b1; ce = 1'b1; start = 1'b0;
    push_mask = '0; pop_mask = '0; sp_in = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_sp_out", sp_out, 0);
    chk("rst_reg_sel", reg_sel, 0);
    chk("rst_reg_we", reg_we, 0);
    reset = 1'b0;

    // push sequence, immediate ack
    launch(16'h01DF, 16'h0000, 16'h0100, 0);
    chk("busy_after_start", busy, 1);
    finish_seq();
    ea = '{16'h00FE, 16'h00FC, 16'h00FA, 16'h00F8, 16'h00F6, 16'h00F4, 16'h00F2, 16'h00F0};
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
    check_bus(8, 1'b1, ea, es);
    chk("push_sp_out", sp_final, 16'h00F0);
    chk("busy_after_done", busy, 0);

    // pop sequence with skip bit 5
    launch(16'h0000, 16'h01EF, 16'h00F0, 0);
    finish_seq();
    ea = '{16'h00F0, 16'h00F2, 16'h00F4, 16'h00F8, 16'h00FA, 16'h00FC, 16'h00FE, 16'h0000};
    es = '{4'd8, 4'd7, 4'd6, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    check_bus(7, 1'b0, ea, es);
    chk("pop_sp_out", sp_final, 16'h0100);

    // SP wrap below zero
    launch(16'h4000, 16'h0000, 16'h0000, 0);
    finish_seq();
    ea = '{16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    es = '{4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    check_bus(1, 1'b1, ea, es);
    chk("wrap_sp_out", sp_final, 16'hFFFE);

    // empty masks
    launch(16'h0000, 16'h0000, 16'h1234, 0);
    finish_seq();
    chk("empty_done_latency", done_cyc - start_cyc, 1);
    chk("empty_sp_out", sp_final, 16'h1234);
    chk("empty_no_bus", req_cycles, 0);

    // push then pop with 3 wait states, plus a start pulse while busy
    launch(16'h0001, 16'h0002, 16'h0010, 3);
    repeat (2) @(posedge clk);
    #1;
    push_mask = 16'hFFFF; sp_in = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_seq();
    chk("pp_bus_count", b_addr.size(), 2);
    if (b_addr.size() == 2) begin
      chk("pp_w_addr", b_addr[0], 16'h000E);
      chk("pp_w_write", b_wr[0], 1);
      chk("pp_w_sel", b_sel[0], 0);
      chk("pp_w_data", b_data[0], 16'hC0D0);
      chk("pp_r_addr", b_addr[1], 16'h000E);
      chk("pp_r_write", b_wr[1], 0);
      chk("pp_r_sel", b_sel[1], 1);
    end
    chk("pp_reg_we_count", r_sel.size(), 1);
    if (r_sel.size() == 1) chk("pp_reg_wdata", r_data[0], 16'h000E ^ 16'h5A5A);
    chk("pp_req_cycles", req_cycles, 8);
    chk("pp_addr_stable", unstable, 0);
    chk("pp_sp_out", sp_final, 16'h0010);

    // clock enable low freezes the sequence in SCAN
    launch(16'h0001, 16'h0000, 16'h0020, 0);
    ce = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ce_busy_held", busy, 1);
    chk("ce_no_req", bus_req, 0);
    chk("ce_no_done", done_cnt, 0);
    ce = 1'b1;
    finish_seq();
    chk("ce_bus_count", b_addr.size(), 1);
    if (b_addr.size() == 1) chk("ce_addr", b_addr[0], 16'h001E);
    chk("ce_sp_out", sp_final, 16'h001E);

    // reset while waiting for ack
    launch(16'h0003, 16'h0000, 16'h0040, 1000);
    for (int k = 0; k < 20; k++) begin
      if (bus_req) break;
      @(posedge clk);
      #1;
    end
    chk("rst_seq_req_seen", bus_req, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_seq_bus_req", bus_req, 0);
    chk("rst_seq_busy", busy, 0);
    chk("rst_seq_addr", bus_addr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_seq_no_done", done_cnt, 0);
    chk("rst_seq_no_sp_we", spwe_cnt, 0);
    chk("rst_seq_no_reg_we", r_sel.size(), 0);
    waits_cfg = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
